hp_arbiter: RTL

- Owns the player's hit-point register and shares it between damage requesters: boss contact, projectiles, hazards.
- Round-robin arbiter grants one damage hit per window, then enforces a frame-based invulnerability period.
- Applies heal pulses, flags death for the game-state logic, and drives char_hp to the HUD and the character path.
- Sits beside the character movement controller; uses the same 65 MHz clock and the same game_active encoding: 0 menu, 1 play, 2 over.

---
 rtl/hp_arbiter_pkg.sv | 15 +
 rtl/hp_arbiter_rr.sv | 30 +++
 rtl/hp_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/hp_arbiter_pkg.sv
// hp_arbiter_pkg: shared game constants and HP state encoding.
//   CLK_HZ/FPS        system clock and frame rate used to derive DEF_FRAME_TICKS
//   DEF_MAX_HP        spawn / new-game HP and heal ceiling
//   GAME_*            game_active encoding shared with the movement controller
//   hp_state_t        READY / INVULN / DEAD
package hp_arbiter_pkg;
    localparam int CLK_HZ          = 65_000_000;
    localparam int FPS             = 60;
    localparam int DEF_FRAME_TICKS = CLK_HZ / FPS;
    localparam int DEF_MAX_HP      = 10;
    localparam logic [1:0] GAME_MENU = 2'd0;
    localparam logic [1:0] GAME_PLAY = 2'd1;
    localparam logic [1:0] GAME_OVER = 2'd2;
    typedef enum logic [1:0] {READY, INVULN, DEAD} hp_state_t;
endpackage

// File: rtl/hp_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the first set request at or after ptr.
//   req    in  N   request vector
//   ptr    in      index the search starts from
//   gnt    out N   one-hot winner (all zero when no request)
//   valid  out 1   any request present
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]                       req,
    input  logic [$clog2(N > 1 ? N : 2)-1:0]   ptr,
    output logic [N-1:0]                       gnt,
    output logic                               valid
);
    localparam int PW = $clog2(N > 1 ? N : 2);
    logic [PW-1:0] idx;
    logic found;
    always_comb begin
        gnt = '0;
        found = 1'b0;
        idx = ptr;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found = 1'b1;
            end
        end
    end
    assign valid = |req;
endmodule

// File: rtl/hp_arbiter.sv
// hp_arbiter: player HP register shared between round-robin damage requesters.
//   clk, rst      65 MHz clock, asynchronous active-high reset
//   game_active   0 menu, 1 play, 2 over; a !=1 -> 1 transition starts a new game
//   dmg_req/amt   level-held damage requests, 4-bit amount per requester
//   dmg_gnt       registered one-cycle grant pulse
//   heal_req/amt  one-cycle heal pulse and amount
//   char_hp       current HP; invuln / char_dead decode the state
// Optional: define HP_REGEN_EN to add +1 HP every REGEN_FRAMES frames while READY.
module hp_arbiter
    import hp_arbiter_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int MAX_HP        = DEF_MAX_HP,
    parameter int INVULN_FRAMES = 60,
    parameter int FRAME_TICKS   = DEF_FRAME_TICKS
`ifdef HP_REGEN_EN
    , parameter int REGEN_FRAMES = 120
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         game_active,
    input  logic [N_REQ-1:0]   dmg_req,
    input  logic [4*N_REQ-1:0] dmg_amt,
    output logic [N_REQ-1:0]   dmg_gnt,
    input  logic               heal_req,
    input  logic [3:0]         heal_amt,
    output logic [3:0]         char_hp,
    output logic               invuln,
    output logic               char_dead
);
    localparam int PW = $clog2(N_REQ > 1 ? N_REQ : 2);
    localparam int FW = $clog2(FRAME_TICKS > 1 ? FRAME_TICKS : 2);
    localparam int IW = $clog2(INVULN_FRAMES + 1);

    hp_state_t state, state_nxt;
    logic [3:0] hp_nxt, hp_sum, dmg;
    logic [PW-1:0] ptr, ptr_nxt, ptr_inc;
    logic [FW-1:0] frame_cnt;
    logic [IW-1:0] icnt, icnt_nxt;
    logic [1:0] prev_ga;
    logic [N_REQ-1:0] gnt_c, gnt_nxt;
    logic [5:0] net;
    logic any_req, frame_tick, new_game, play, grant, heal_ok, regen;

    rr_arbiter #(.N(N_REQ)) u_rr (.req(dmg_req), .ptr(ptr), .gnt(gnt_c), .valid(any_req));

    assign frame_tick = frame_cnt == FW'(FRAME_TICKS - 1);
    assign new_game   = game_active == GAME_PLAY && prev_ga != GAME_PLAY;
    // The new-game cycle itself is frozen so it wins over any grant or heal.
    assign play       = game_active == GAME_PLAY && !new_game;
    assign grant      = play && state == READY && any_req;
    assign heal_ok    = heal_req && play && state != DEAD;

`ifdef HP_REGEN_EN
    localparam int RW = $clog2(REGEN_FRAMES > 1 ? REGEN_FRAMES : 2);
    logic [RW-1:0] rcnt;
    logic regen_due;
    assign regen_due = play && state == READY && char_hp < 4'(MAX_HP) && frame_tick;
    assign regen     = regen_due && rcnt == RW'(REGEN_FRAMES - 1);
    always_ff @(posedge clk or posedge rst)
        if (rst) rcnt <= '0;
        else if (new_game || grant || state == DEAD || regen) rcnt <= '0;
        else if (regen_due) rcnt <= rcnt + 1'b1;
`else
    assign regen = 1'b0;
`endif

    always_comb begin
        dmg = '0;
        ptr_inc = ptr;
        for (int i = 0; i < N_REQ; i++)
            if (gnt_c[i]) begin
                dmg = dmg_amt[4*i +: 4];
                ptr_inc = PW'((i + 1) % N_REQ);
            end
        // Two's-complement 6-bit sum; bit 5 set means the result went below zero.
        net = {2'b00, char_hp} - (grant ? {2'b00, dmg} : 6'd0)
            + (heal_ok ? {2'b00, heal_amt} : 6'd0) + {5'd0, regen};
        hp_sum = net[5] ? 4'd0 : net > 6'(MAX_HP) ? 4'(MAX_HP) : net[3:0];
        hp_nxt = hp_sum;
        state_nxt = state;
        icnt_nxt = icnt;
        ptr_nxt = grant ? ptr_inc : ptr;
        gnt_nxt = grant ? gnt_c : '0;
        if (new_game) begin
            hp_nxt = 4'(MAX_HP);
            state_nxt = READY;
            icnt_nxt = '0;
        end else if (grant) begin
            state_nxt = hp_sum == 4'd0 ? DEAD : dmg != 4'd0 ? INVULN : state;
            icnt_nxt = (hp_sum != 4'd0 && dmg != 4'd0) ? IW'(INVULN_FRAMES) : icnt;
        end else if (play && state == INVULN && frame_tick) begin
            icnt_nxt = icnt - 1'b1;
            state_nxt = icnt == IW'(1) ? READY : INVULN;
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            frame_cnt <= '0;
            prev_ga   <= GAME_MENU;
            state     <= READY;
            char_hp   <= 4'(MAX_HP);
            ptr       <= '0;
            icnt      <= '0;
            dmg_gnt   <= '0;
            invuln    <= 1'b0;
            char_dead <= 1'b0;
        end else begin
            frame_cnt <= frame_tick ? '0 : frame_cnt + 1'b1;
            prev_ga   <= game_active;
            state     <= state_nxt;
            char_hp   <= hp_nxt;
            ptr       <= ptr_nxt;
            icnt      <= icnt_nxt;
            dmg_gnt   <= gnt_nxt;
            invuln    <= state_nxt == INVULN;
            char_dead <= state_nxt == DEAD;
        end
endmodule
